// File: rtl/param_shift_rotate_unit.sv
// rtl/param_shift_rotate_unit.sv - WIDTH-bit shift/rotate register, immediate or stepped execution; carry output via BSH_CARRY_EN
module param_shift_rotate_unit #(
    parameter int WIDTH    = 8,
    parameter int SHAMT_W  = 3,
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [2:0]         op_code,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               fill,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               step_mode,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
`ifdef BSH_CARRY_EN
    ,
    output logic               carry
`endif
);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_SLL   = 3'b001;
    localparam logic [2:0] OP_SRL   = 3'b010;
    localparam logic [2:0] OP_SRA   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam int                CHAIN_LEN = (1 << SHAMT_W) - 1;

    typedef enum logic {
        ST_IDLE,
        ST_STEP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [TICK_W-1:0]    tick_cnt;
    logic [SHAMT_W-1:0]   remaining;
    logic [2:0]           op_q;
    logic                 fill_q;
    logic                 accept;
    logic                 start_step;
    logic                 tick_hit;
    logic [WIDTH-1:0]     imm_result;

    function automatic logic is_shift(input logic [2:0] op);
        return (op >= OP_SLL) && (op <= OP_ROR);
    endfunction

    // One 1-bit move; the immediate path is a chain of these so both modes agree bit for bit.
    function automatic logic [WIDTH-1:0] step_data(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] d,
                                                   input logic f);
        case (op)
            OP_SLL:  return {d[WIDTH-2:0], f};
            OP_SRL:  return {f, d[WIDTH-1:1]};
            OP_SRA:  return {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  return {d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  return {d[0], d[WIDTH-1:1]};
            default: return d;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] shift_chain(input logic [2:0] op,
                                                     input logic [WIDTH-1:0] d,
                                                     input logic [SHAMT_W-1:0] amt,
                                                     input logic f);
        logic [WIDTH-1:0] r;
        r = d;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (amt > SHAMT_W'(i)) r = step_data(op, r, f);
        end
        return r;
    endfunction

`ifdef BSH_CARRY_EN
    function automatic logic step_carry(input logic [2:0] op, input logic [WIDTH-1:0] d);
        case (op)
            OP_SLL, OP_ROL:         return d[WIDTH-1];
            OP_SRL, OP_SRA, OP_ROR: return d[0];
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic carry_chain(input logic [2:0] op,
                                         input logic [WIDTH-1:0] d,
                                         input logic [SHAMT_W-1:0] amt,
                                         input logic f,
                                         input logic c);
        logic [WIDTH-1:0] r;
        logic             cc;
        r  = d;
        cc = c;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (amt > SHAMT_W'(i)) begin
                cc = step_carry(op, r);
                r  = step_data(op, r, f);
            end
        end
        return cc;
    endfunction
`endif

    assign tick_hit = (tick_cnt == TICK_LAST);

    // Result of an op completed at its accept edge.
    always_comb begin
        imm_result = data_out;
        case (op_code)
            OP_LOAD:  imm_result = load_data;
            OP_CLEAR: imm_result = {WIDTH{fill}};
            OP_NOP:   imm_result = data_out;
            default:  imm_result = shift_chain(op_code, data_out, amount, fill);
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state, handshake and strobes.
    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        start_step = 1'b0;
        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                accept   = op_valid;
                if (op_valid && is_shift(op_code) && step_mode && (amount != '0)) begin
                    start_step = 1'b1;
                    state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                busy = 1'b1;
                if (tick_hit && (remaining == SHAMT_W'(1))) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Data register, step bookkeeping and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            done      <= 1'b0;
            op_q      <= OP_NOP;
            fill_q    <= 1'b0;
            remaining <= '0;
            tick_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q      <= op_code;
                fill_q    <= fill;
                remaining <= amount;
                tick_cnt  <= '0;
                if (!start_step) begin
                    data_out <= imm_result;
                    done     <= 1'b1;
                end
            end else if (state == ST_STEP) begin
                if (tick_hit) begin
                    tick_cnt  <= '0;
                    data_out  <= step_data(op_q, data_out, fill_q);
                    remaining <= remaining - SHAMT_W'(1);
                    if (remaining == SHAMT_W'(1)) done <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end
            end
        end
    end

`ifdef BSH_CARRY_EN
    // Last bit to leave the register; held by NOP and zero-distance moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (accept && !start_step) begin
            case (op_code)
                OP_LOAD, OP_CLEAR: carry <= 1'b0;
                OP_NOP:            carry <= carry;
                default:           carry <= carry_chain(op_code, data_out, amount, fill, carry);
            endcase
        end else if ((state == ST_STEP) && tick_hit) begin
            carry <= step_carry(op_q, data_out);
        end
    end
`endif

endmodule

// File: tb/tb_param_shift_rotate_unit.sv
// tb/tb_param_shift_rotate_unit.sv - self-checking bench for param_shift_rotate_unit (WIDTH=8, TICK_DIV=4)
module tb_param_shift_rotate_unit;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [2:0] amount;
    logic       fill;
    logic [7:0] load_data;
    logic       step_mode;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
`ifdef BSH_CARRY_EN
    logic       carry;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_data;
    logic       m_carry;

    param_shift_rotate_unit #(.WIDTH(8), .SHAMT_W(3), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .amount(amount), .fill(fill), .load_data(load_data),
        .step_mode(step_mode), .data_out(data_out), .busy(busy), .done(done)
`ifdef BSH_CARRY_EN
        , .carry(carry)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_op(input logic [2:0] c, input logic [7:0] d,
                                            input int k, input logic f, input logic [7:0] ld);
        int                dd;
        int                r;
        int                kk;
        logic signed [7:0] s;
        dd = d;
        s  = d;
        kk = k % 8;
        case (c)
            3'd0: r = ld;
            3'd1: r = (dd << k) | (f ? ((1 << k) - 1) : 0);
            3'd2: r = (dd >> k) | (f ? ((255 << (8 - k)) & 255) : 0);
            3'd3: r = int'(8'(s >>> k));
            3'd4: r = (dd << kk) | (dd >> (8 - kk));
            3'd5: r = (dd >> kk) | (dd << (8 - kk));
            3'd6: r = dd;
            default: r = f ? 255 : 0;
        endcase
        return 8'(r & 255);
    endfunction

    function automatic logic model_cy(input logic [2:0] c, input logic [7:0] d,
                                      input int k, input logic cur);
        if (c == 3'd0 || c == 3'd7) return 1'b0;
        if (c == 3'd6 || k == 0)    return cur;
        if (c == 3'd1 || c == 3'd4) return d[8 - k];
        return d[k - 1];
    endfunction

    task automatic model_apply(input logic [2:0] c, input int k, input logic f, input logic [7:0] ld);
        m_carry = model_cy(c, m_data, k, m_carry);
        m_data  = model_op(c, m_data, k, f, ld);
    endtask

    task automatic do_op(input logic [2:0] c, input logic [2:0] k, input logic f,
                         input logic [7:0] ld, input logic sm);
        @(negedge clk);
        op_code = c; amount = k; fill = f; load_data = ld; step_mode = sm; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", data_out); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", op_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
`ifdef BSH_CARRY_EN
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b want=0", carry); end
`endif
        rst = 1'b0;
        m_data = 8'h00;
        m_carry = 1'b0;
    endtask

    task automatic test_directed;
        do_op(3'd0, 3'd0, 1'b0, 8'hB4, 1'b0); model_apply(3'd0, 0, 1'b0, 8'hB4);
        checks++; if (data_out !== 8'hB4) begin errors++; $display("FAIL load_b4 got=%h want=b4", data_out); end
        do_op(3'd4, 3'd3, 1'b0, 8'h00, 1'b0); model_apply(3'd4, 3, 1'b0, 8'h00);
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL rol3_back_to_back got=%h want=a5", data_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rol3_done got=%b want=1", done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b want=0", done); end
        do_op(3'd0, 3'd0, 1'b0, 8'h90, 1'b0); model_apply(3'd0, 0, 1'b0, 8'h90);
        do_op(3'd3, 3'd2, 1'b0, 8'h00, 1'b0); model_apply(3'd3, 2, 1'b0, 8'h00);
        checks++; if (data_out !== 8'hE4) begin errors++; $display("FAIL sra2 got=%h want=e4", data_out); end
        do_op(3'd0, 3'd0, 1'b0, 8'h3C, 1'b0); model_apply(3'd0, 0, 1'b0, 8'h3C);
        do_op(3'd1, 3'd4, 1'b1, 8'h00, 1'b0); model_apply(3'd1, 4, 1'b1, 8'h00);
        checks++; if (data_out !== 8'hCF) begin errors++; $display("FAIL sll4_fill1 got=%h want=cf", data_out); end
    endtask

    task automatic test_random_immediate;
        logic [2:0] c;
        logic [2:0] k;
        logic       f;
        logic [7:0] ld;
        logic       sm;
        for (int i = 0; i < 40; i++) begin
            c  = 3'($urandom_range(0, 7));
            k  = 3'($urandom_range(0, 7));
            f  = 1'($urandom_range(0, 1));
            ld = 8'($urandom);
            sm = (k == 3'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_op(c, k, f, ld, sm);
            model_apply(c, int'(k), f, ld);
            checks++; if (data_out !== m_data) begin errors++; $display("FAIL imm_data op=%0d amt=%0d got=%h want=%h", c, k, data_out, m_data); end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL imm_done op=%0d got=%b want=1", c, done); end
`ifdef BSH_CARRY_EN
            checks++; if (carry !== m_carry) begin errors++; $display("FAIL imm_carry op=%0d amt=%0d got=%b want=%b", c, k, carry, m_carry); end
`endif
        end
    endtask

    task automatic test_stepped_directed;
        do_op(3'd0, 3'd0, 1'b0, 8'h81, 1'b0); model_apply(3'd0, 0, 1'b0, 8'h81);
        do_op(3'd5, 3'd2, 1'b0, 8'h00, 1'b1);
        checks++; if (data_out !== 8'h81 || busy !== 1'b1 || op_ready !== 1'b0)
            begin errors++; $display("FAIL step_start got=%h/%b/%b want=81/1/0", data_out, busy, op_ready); end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin op_valid = 1'b1; op_code = 3'd0; load_data = 8'hFF; step_mode = 1'b0; end
            if (c == 3) op_valid = 1'b0;
            if (c == 4) begin
                checks++; if (data_out !== 8'hC0) begin errors++; $display("FAIL step_n4 got=%h want=c0", data_out); end
            end
            if (c == 7) begin
                checks++; if (data_out !== 8'hC0 || done !== 1'b0) begin errors++; $display("FAIL step_n7 got=%h/%b want=c0/0", data_out, done); end
            end
            if (c == 8) begin
                checks++; if (data_out !== 8'h60) begin errors++; $display("FAIL step_n8 got=%h want=60", data_out); end
                checks++; if (done !== 1'b1 || op_ready !== 1'b1 || busy !== 1'b0)
                    begin errors++; $display("FAIL step_n8_hs got=%b/%b/%b want=1/1/0", done, op_ready, busy); end
            end
        end
        model_apply(3'd5, 2, 1'b0, 8'h00);
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL step_done_drop got=%b want=0", done); end
    endtask

    task automatic test_random_stepped;
        logic [2:0] c;
        logic [2:0] k;
        logic       f;
        logic [7:0] ld;
        int         cycles;
        logic       got;
        for (int i = 0; i < 12; i++) begin
            ld = 8'($urandom);
            do_op(3'd0, 3'd0, 1'b0, ld, 1'b0); model_apply(3'd0, 0, 1'b0, ld);
            c = 3'($urandom_range(1, 5));
            k = 3'($urandom_range(1, 7));
            f = 1'($urandom_range(0, 1));
            do_op(c, k, f, 8'h00, 1'b1);
            model_apply(c, int'(k), f, 8'h00);
            cycles = 0;
            got = 1'b0;
            while (!got && cycles < 64) begin
                @(posedge clk); #1;
                cycles++;
                if (done) begin
                    got = 1'b1;
                    op_valid = 1'b0;
                end else begin
                    op_valid  = 1'($urandom_range(0, 1));
                    op_code   = 3'($urandom_range(0, 7));
                    amount    = 3'($urandom);
                    fill      = 1'($urandom_range(0, 1));
                    load_data = 8'($urandom);
                end
            end
            op_valid = 1'b0;
            checks++; if (!got) begin errors++; $display("FAIL step_timeout op=%0d amt=%0d got=none want=done", c, k); end
            checks++; if (cycles != int'(k) * TD) begin errors++; $display("FAIL step_latency op=%0d got=%0d want=%0d", c, cycles, int'(k) * TD); end
            checks++; if (data_out !== m_data) begin errors++; $display("FAIL step_data op=%0d amt=%0d got=%h want=%h", c, k, data_out, m_data); end
`ifdef BSH_CARRY_EN
            checks++; if (carry !== m_carry) begin errors++; $display("FAIL step_carry op=%0d amt=%0d got=%b want=%b", c, k, carry, m_carry); end
`endif
        end
    endtask

    task automatic test_reset_mid_step;
        logic any_done;
        do_op(3'd0, 3'd0, 1'b0, 8'h5A, 1'b0);
        do_op(3'd1, 3'd7, 1'b1, 8'h00, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_data = 8'h00;
        m_carry = 1'b0;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h want=00", data_out); end
        checks++; if (op_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b/%b want=1/0", op_ready, busy); end
        any_done = 1'b0;
        for (int c = 0; c < 32; c++) begin
            if (done) any_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (any_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got=%b want=0", any_done); end
        checks++; if (data_out !== 8'h00 || op_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle got=%h/%b want=00/1", data_out, op_ready); end
    endtask

`ifdef BSH_CARRY_EN
    task automatic test_carry;
        do_op(3'd0, 3'd0, 1'b0, 8'h01, 1'b0); model_apply(3'd0, 0, 1'b0, 8'h01);
        do_op(3'd2, 3'd1, 1'b0, 8'h00, 1'b0); model_apply(3'd2, 1, 1'b0, 8'h00);
        checks++; if (data_out !== 8'h00 || carry !== 1'b1) begin errors++; $display("FAIL carry_srl got=%h/%b want=00/1", data_out, carry); end
        do_op(3'd6, 3'd0, 1'b0, 8'h00, 1'b0); model_apply(3'd6, 0, 1'b0, 8'h00);
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL carry_nop_hold got=%b want=1", carry); end
        do_op(3'd0, 3'd0, 1'b0, 8'h01, 1'b0); model_apply(3'd0, 0, 1'b0, 8'h01);
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL carry_load_clr got=%b want=0", carry); end
    endtask
`endif

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = 3'd6; amount = 3'd0;
        fill = 1'b0; load_data = 8'h00; step_mode = 1'b0;
        m_data = 8'h00; m_carry = 1'b0;
        test_reset;
        test_directed;
        test_random_immediate;
        test_stepped_directed;
        test_random_stepped;
        test_reset_mid_step;
`ifdef BSH_CARRY_EN
        test_carry;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
